// File: rtl/input_conditioner_if.sv
// Pin-side and FSM-side signal bundle of the input conditioner.
// The conditioner takes the slave modport; whatever drives the raw pins takes master.
interface input_conditioner_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned N_SW  = 8
);
  logic [N_BTN-1:0] i_btn;
  logic [N_SW-1:0]  i_sw;
  logic [N_BTN-1:0] o_btn_level;
  logic [N_BTN-1:0] o_btn_press;
  logic [N_BTN-1:0] o_btn_release;
  logic [N_BTN-1:0] o_btn_repeat;
  logic [N_SW-1:0]  o_sw;
  logic             o_sw_changed;

  modport master (
    output i_btn, i_sw,
    input  o_btn_level, o_btn_press, o_btn_release, o_btn_repeat, o_sw, o_sw_changed
  );

  modport slave (
    input  i_btn, i_sw,
    output o_btn_level, o_btn_press, o_btn_release, o_btn_repeat, o_sw, o_sw_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchronisation and per-bit debounce of buttons and switches,
// with registered press/release/change pulses and a per-button auto-repeat FSM.
module input_conditioner #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned N_SW          = 8,
  parameter int unsigned DB_CYCLES     = 500_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input logic                clk,
  input logic                rst,
  input_conditioner_if.slave bus
);

  localparam int unsigned N_ALL  = N_BTN + N_SW;
  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HR_W   = $clog2(HR_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
  localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, HOLD_WAIT, REPEATING} rep_state_t;

  logic [N_ALL-1:0] w_raw, r_sync1, r_sync2, r_stable, w_upd;
  logic [DB_W-1:0]  r_db_cnt [N_ALL];
  logic [N_BTN-1:0] w_rise, w_fall, w_rep_nxt;
  logic [N_BTN-1:0] r_press, r_release, r_repeat;
  logic             r_sw_changed;

  rep_state_t       r_state     [N_BTN];
  rep_state_t       w_state_nxt [N_BTN];
  logic [HR_W-1:0]  r_hr_cnt    [N_BTN];
  logic [HR_W-1:0]  w_hr_cnt_nxt[N_BTN];

  // Buttons occupy the low bits and switches the high bits of one shared debounce array.
  assign w_raw = {bus.i_sw, bus.i_btn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_upd = '0;
    for (int unsigned i = 0; i < N_ALL; i++)
      w_upd[i] = (r_sync2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < N_ALL; i++) r_db_cnt[i] <= '0;
    end else begin
      r_stable <= r_stable ^ w_upd;
      for (int unsigned i = 0; i < N_ALL; i++) begin
        if ((r_sync2[i] == r_stable[i]) || w_upd[i]) r_db_cnt[i] <= '0;
        else                                         r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise = w_upd[N_BTN-1:0] & ~r_stable[N_BTN-1:0];
  assign w_fall = w_upd[N_BTN-1:0] &  r_stable[N_BTN-1:0];

  // Repeat FSM: state register (pulse outputs registered alongside)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_press      <= '0;
      r_release    <= '0;
      r_repeat     <= '0;
      r_sw_changed <= 1'b0;
      for (int unsigned b = 0; b < N_BTN; b++) begin
        r_state[b]  <= RELEASED;
        r_hr_cnt[b] <= '0;
      end
    end else begin
      r_press      <= w_rise;
      r_release    <= w_fall;
      r_repeat     <= w_rep_nxt;
      r_sw_changed <= |w_upd[N_ALL-1:N_BTN];
      for (int unsigned b = 0; b < N_BTN; b++) begin
        r_state[b]  <= w_state_nxt[b];
        r_hr_cnt[b] <= w_hr_cnt_nxt[b];
      end
    end
  end

  // Next state: the debounced fall overrides everything, so release beats a terminal count
  always_comb begin
    for (int unsigned b = 0; b < N_BTN; b++) begin
      w_state_nxt[b]  = r_state[b];
      w_hr_cnt_nxt[b] = r_hr_cnt[b];
      if (w_fall[b]) begin
        w_state_nxt[b]  = RELEASED;
        w_hr_cnt_nxt[b] = '0;
      end else begin
        unique case (r_state[b])
          RELEASED: if (w_rise[b]) begin
            w_state_nxt[b]  = HOLD_WAIT;
            w_hr_cnt_nxt[b] = '0;
          end
          HOLD_WAIT: if (r_hr_cnt[b] == HOLD_LAST) begin
            w_state_nxt[b]  = REPEATING;
            w_hr_cnt_nxt[b] = '0;
          end else begin
            w_hr_cnt_nxt[b] = r_hr_cnt[b] + 1'b1;
          end
          REPEATING: if (r_hr_cnt[b] == REP_LAST) w_hr_cnt_nxt[b] = '0;
                     else                         w_hr_cnt_nxt[b] = r_hr_cnt[b] + 1'b1;
          default: begin
            w_state_nxt[b]  = RELEASED;
            w_hr_cnt_nxt[b] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rep_nxt = '0;
    for (int unsigned b = 0; b < N_BTN; b++)
      w_rep_nxt[b] = !w_fall[b] &&
                     (((r_state[b] == HOLD_WAIT) && (r_hr_cnt[b] == HOLD_LAST)) ||
                      ((r_state[b] == REPEATING) && (r_hr_cnt[b] == REP_LAST)));
  end

  assign bus.o_btn_level   = r_stable[N_BTN-1:0];
  assign bus.o_btn_press   = r_press;
  assign bus.o_btn_release = r_release;
  assign bus.o_btn_repeat  = r_repeat;
  assign bus.o_sw          = r_stable[N_ALL-1:N_BTN];
  assign bus.o_sw_changed  = r_sw_changed;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage between the board pins and the control FSM: synchronises and debounces the four operator buttons and eight mode switches. It emits clean levels plus single-cycle press, release and auto-repeat pulses, so the FSM never sees metastable or bouncing inputs. It runs on the divided system clock (`clk`) and sits directly upstream of the FSM's `btn`/`sw` inputs.

## Interface
- `N_BTN`, 4, number of push buttons conditioned.
- `N_SW`, 8, number of slide switches conditioned.
- `DB_CYCLES`, 500_000, consecutive stable cycles required to accept a new level (20 ms at 25 MHz); must be ≥ 1.
- `HOLD_CYCLES`, 25_000_000, held-press duration before the first repeat pulse (1 s); must be ≥ 1.
- `REPEAT_CYCLES`, 5_000_000, interval between subsequent repeat pulses (200 ms); must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_btn`  in  N_BTN  raw button pins; asynchronous.
- `i_sw`  in  N_SW  raw switch pins; asynchronous.
- `o_btn_level`  out  N_BTN  debounced button levels.
- `o_btn_press`  out  N_BTN  one-cycle pulse per bit on a debounced 0→1 transition.
- `o_btn_release`  out  N_BTN  one-cycle pulse per bit on a debounced 1→0 transition.
- `o_btn_repeat`  out  N_BTN  one-cycle auto-repeat pulse per bit while the button is held.
- `o_sw`  out  N_SW  debounced switch levels.
- `o_sw_changed`  out  1  one-cycle pulse when any bit of `o_sw` changes.

## Operation
- Synchroniser: every raw bit passes through two flip-flops before use; nothing downstream reads a raw pin.
- Debounce, per bit, independently:
  - Keep a stable value S and a counter C of width clog2(DB_CYCLES+1).
  - If the synced value equals S, C clears to 0.
  - Otherwise C increments. When C reaches DB_CYCLES−1 while still differing, S takes the synced value and C clears.
  - A glitch shorter than DB_CYCLES cycles never changes S.
- Button outputs: `o_btn_level` = S. Press and release pulses are registered and assert in the same cycle `o_btn_level` first shows the new value.
- Repeat FSM, per button:
  - States are RELEASED, HOLD_WAIT and REPEATING.
  - RELEASED→HOLD_WAIT on press; the hold counter clears.
  - HOLD_WAIT counts cycles with the level high. At HOLD_CYCLES, it pulses `o_btn_repeat` and moves to REPEATING with the counter cleared.
  - REPEATING pulses every REPEAT_CYCLES cycles.
  - Release from any state returns to RELEASED with no repeat pulse that cycle. The release pulse takes precedence when the repeat terminal count coincides with release.
  - Hold and repeat counters saturate-free: width is clog2 of max(HOLD_CYCLES, REPEAT_CYCLES)+1.
- Switches: same debounce as buttons, with no repeat FSM. `o_sw_changed` pulses in the cycle `o_sw` changes; a single pulse covers any number of bits changing in the same cycle.
- Independence: all bits are fully independent. Simultaneous presses on several buttons produce coincident pulses, with no arbitration.

## Timing
- Reset (asynchronous, on `rst` high) clears:
  - all synchroniser flops, S values and counters;
  - every output to 0;
  - every repeat FSM to RELEASED.
- After reset deassertion, an input already high is treated as a new transition. A held button yields `o_btn_press` after full latency, and a high switch yields `o_sw_changed`.
- Latency: a raw edge that stays stable becomes visible on `o_btn_level`/`o_sw` and the pulses exactly DB_CYCLES+2 clock edges after the first sampling edge. This is 2 edges for synchronisation plus DB_CYCLES for debounce.
- First `o_btn_repeat`: HOLD_CYCLES cycles after the `o_btn_press` cycle.
- Subsequent repeats: every REPEAT_CYCLES cycles thereafter.
- Pulse width: every pulse output is high for exactly one cycle. Press and release for the same bit never assert in the same cycle.
- Reset mid-debounce or mid-hold:
  - the count is abandoned and no pulse is emitted;
  - counting restarts from 0 after release of `rst`.

## Test plan
Parameters: DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- **Reset values:** assert `rst` with all inputs high → every output is 0. Release `rst` → `o_btn_level`=4'hF, `o_btn_press`=4'hF pulses, `o_sw_changed` pulses, all exactly 6 edges after the first sample.
- **Bounce rejection:** toggle `i_btn[0]` high 3 cycles / low 1, four times, then hold high → level rises only after the final 4-cycle stable window. There is exactly one `o_btn_press[0]`, and none earlier.
- **Auto-repeat:** hold `i_btn[2]` for 50 cycles after press → `o_btn_repeat[2]` pulses at press+20, +28, +36 and +44. Release → one `o_btn_release[2]`, and no further repeats.
- **Release/repeat collision:** time the release so the debounced fall lands on the repeat terminal cycle → `o_btn_release` pulses and `o_btn_repeat` stays 0.
- **Switch change:** change `i_sw` from 8'h00 to 8'hA5 in one cycle → after 6 edges, `o_sw`=8'hA5 and a single-cycle `o_sw_changed` pulse. A 3-cycle glitch on `i_sw[7]` → no change.
- **Reset mid-hold:** press `i_btn[1]`, then assert `rst` at press+10 for 2 cycles and keep the button held → all outputs go to 0 immediately. A fresh `o_btn_press[1]` follows 6 edges after reset release, then the first repeat comes 20 cycles later.
